// File: rtl/imem_boot_loader.sv
// Boot loader for the byte-organised instruction memory.
// Accepts 32-bit words on a valid/ready stream and writes each one as four
// bytes, MSB first. The CPU is held in hold until the program is complete,
// and then the CPU fetch address is passed through to the memory read port.
module imem_boot_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       imem_addr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-2:0] word_count
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned WC_W  = ADDR_W - 1;
  // The pointer is one bit wider than the address so that "memory full" can
  // be told apart from "memory empty".
  localparam logic [PTR_W-1:0] FULL_PTR = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PTR_W-1:0]  r_ptr;
  logic [1:0]        r_bidx;
  logic [31:0]       r_wbuf;
  logic              r_last_q;
  logic [WC_W-1:0]   r_word_count;
  logic              w_full;
  logic              w_accept;

  assign w_full     = (r_ptr == FULL_PTR);
  assign w_accept   = (r_state == S_LOAD) && ld_valid && ld_ready;
  assign word_count = r_word_count;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          w_next = S_WRITE;
        end else if (ld_valid && w_full) begin
          w_next = S_ERR;
        end
      end
      S_WRITE: begin
        if (r_bidx == 2'd3) begin
          w_next = r_last_q ? S_DONE : S_LOAD;
        end
      end
      S_DONE: begin
        if (reload) begin
          w_next = S_LOAD;
        end
      end
      S_ERR: begin
        w_next = S_ERR;
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  // Output decode; memory-side outputs depend only on registered state.
  always_comb begin
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = r_ptr[ADDR_W-1:0];
    mem_wdata = r_wbuf[31:24];
    imem_addr = 32'(r_ptr[ADDR_W-1:0]);
    cpu_hold  = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (r_bidx)
      2'd0:    mem_wdata = r_wbuf[31:24];
      2'd1:    mem_wdata = r_wbuf[23:16];
      2'd2:    mem_wdata = r_wbuf[15:8];
      default: mem_wdata = r_wbuf[7:0];
    endcase
    case (r_state)
      S_LOAD: begin
        ld_ready = rst_n & ~w_full;
      end
      S_WRITE: begin
        mem_we = 1'b1;
      end
      S_DONE: begin
        cpu_hold  = 1'b0;
        done      = 1'b1;
        imem_addr = fetch_addr;
      end
      S_ERR: begin
        err = 1'b1;
      end
      default: begin
        ld_ready = 1'b0;
      end
    endcase
  end

  // Datapath: word buffer, byte pointer, byte index and completed-word count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_bidx       <= 2'd0;
      r_wbuf       <= 32'd0;
      r_last_q     <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_wbuf   <= ld_data;
            r_last_q <= ld_last;
            r_bidx   <= 2'd0;
          end
        end
        S_WRITE: begin
          r_ptr  <= r_ptr + PTR_W'(1);
          r_bidx <= r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            r_word_count <= r_word_count + WC_W'(1);
          end
        end
        S_DONE: begin
          if (reload) begin
            r_ptr        <= '0;
            r_word_count <= '0;
          end
        end
        default: begin
          r_ptr <= r_ptr;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the byte-organised instruction memory (2**ADDR_W bytes; each 32-bit instruction occupies 4 consecutive bytes, MSB byte at the lowest address).
- Accepts 32-bit instruction words over a valid/ready stream and splits each word into 4 sequential byte writes.
- Holds the mono-cycle CPU in hold while loading.
- Once loading completes, gives the memory read-address port to the CPU fetch path.

Parameters:
- ADDR_W, 10, byte-address width of instruction memory (depth 2**ADDR_W bytes).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted when ld_valid & ld_ready
- ld_data  in  32  instruction word, bits [31:24] written first
- ld_last  in  1  qualifies the final word of the program (sampled with the handshake)
- reload  in  1  single-cycle request to restart loading; honoured only in DONE
- mem_we  out  1  byte write strobe to instruction memory
- mem_waddr  out  ADDR_W  byte write address
- mem_wdata  out  8  write byte
- fetch_addr  in  32  CPU program-counter address
- imem_addr  out  32  read address driven to instruction memory
- cpu_hold  out  1  1 = CPU stalled / PC frozen
- done  out  1  program loaded, CPU running
- err  out  1  overflow: word offered with memory full
- word_count  out  ADDR_W-1  number of words completely written

Behaviour:
- State register: LOAD, WRITE, DONE, ERR. Byte pointer ptr is ADDR_W+1 bits. Byte index bidx is 2 bits. Word buffer wbuf is 32 bits. last_q is 1 bit.
- Reset (rst_n low at a clk edge):
  - state=LOAD, ptr=0, bidx=0, word_count=0, last_q=0.
  - mem_we=0, cpu_hold=1, done=0, err=0.
  - ld_ready is gated by rst_n, so it reads 0 while rst_n=0.
  - A reset in any state, including mid-WRITE, abandons the current word; bytes already written are not undone.
- full = (ptr == 2**ADDR_W).
- LOAD:
  - ld_ready = rst_n & !full.
  - On handshake: wbuf<=ld_data, last_q<=ld_last, bidx<=0, next state WRITE.
  - If ld_valid & full: next state ERR (no write).
  - ld_valid low: stay in LOAD.
- WRITE (always exactly 4 cycles):
  - Each cycle: mem_we=1, mem_waddr=ptr[ADDR_W-1:0], mem_wdata=wbuf[31-8*bidx -: 8]. Then ptr<=ptr+1, bidx<=bidx+1.
  - ld_ready=0 throughout.
  - On bidx==3: word_count<=word_count+1, then next state DONE if last_q, else LOAD.
  - Latency: a word accepted at edge N produces writes in cycles N+1..N+4. Sustained throughput is 1 word per 5 cycles.
- DONE:
  - cpu_hold=0, done=1, mem_we=0, ld_ready=0. ld_valid is ignored.
  - reload=1: ptr<=0, word_count<=0, next state LOAD; cpu_hold returns to 1 on the following cycle.
- ERR:
  - Sticky until reset. err=1, cpu_hold=1, ld_ready=0, mem_we=0. reload is ignored.
- imem_addr = fetch_addr in DONE; otherwise {zero-ext, ptr[ADDR_W-1:0]} (read-back of current write position for debug).
- mem_we, mem_waddr and mem_wdata are registered or decoded directly from state registers, with no combinational path from ld_* to mem_*.
- mem_wdata and mem_waddr may hold any value when mem_we=0. The bench checks them only while mem_we=1.
- Full boundary: with ADDR_W=10, exactly 256 words fit. The 256th word may carry ld_last=1 and go to DONE. A 257th word offered goes to ERR.
- reload in LOAD or WRITE has no effect.

Test Plan:
- Reset, then one word 0x12345678 with ld_last=1 → mem writes (0,0x12),(1,0x34),(2,0x56),(3,0x78) in the 4 cycles after accept; then done=1, cpu_hold=0, word_count=1.
- Three back-to-back words (ld_valid held high; only the third has ld_last=1) → ld_ready pulses once per 5 cycles; addresses 0..11 written in order; word_count=3 → DONE.
- ADDR_W=4 (16 bytes): 4 words without ld_last, then a 5th ld_valid → ld_ready=0, err=1, cpu_hold=1, no write issued. State stays ERR after reload=1.
- In DONE, drive fetch_addr=0x8 → imem_addr=0x8. Pulse reload → cpu_hold=1 next cycle, ptr and word_count=0. Load 0xDEADBEEF with last → bytes at 0..3 rewritten.
- Assert rst_n=0 during the 2nd byte of a word → following cycle mem_we=0, state LOAD, word_count=0. After release, ld_ready=1 and the next word is written from address 0.
- Toggle ld_valid randomly with ld_last on the 5th handshake → exactly 20 mem_we cycles, data matches offered words MSB-first, no write without a preceding handshake.
